// File: rtl/regfile_mp_pkg.sv
// Shared types and default constants for the multi-port register file slice.
package regfile_mp_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_t;

    localparam int          SP_IDX_DEF  = 2;
    // Top of the data memory window; the stack grows down from here.
    localparam logic [31:0] MEM_DEPTH   = 32'h0001_0000;
    localparam logic [31:0] SP_INIT_DEF = 32'h0100_0000 + MEM_DEPTH;

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, issue sets, writeback clears.
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int NREAD = 3,
    parameter int AW    = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               set_en,
    input  logic [AW-1:0]      set_idx,
    input  logic [1:0]         clr_en,
    input  logic [2*AW-1:0]    clr_idx,
    input  logic [NREAD*AW-1:0] rd_addr,
    output logic [NREAD-1:0]   rd_busy
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Set is applied after the clears so a same-cycle issue keeps the entry pending.
    always_comb begin
        busy_next = busy;
        if (flush) begin
            busy_next = '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (clr_en[k]) begin
                    busy_next[clr_idx[k*AW +: AW]] = 1'b0;
                end
            end
            if (set_en) begin
                busy_next[set_idx] = 1'b1;
            end
        end
        busy_next[0] = 1'b0;
    end

    function automatic logic lookup(input logic [AW-1:0] a);
        logic hit;
        hit = busy[a] && (a != '0);
        for (int k = 0; k < 2; k++) begin
            if (clr_en[k] && clr_idx[k*AW +: AW] == a) begin
                hit = 1'b0;
            end
        end
        return hit;
    endfunction

    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NREAD; i++) begin
            rd_busy[i] = lookup(rd_addr[i*AW +: AW]);
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Two-write, NREAD-read register file with bypass, pending-write scoreboard and
// a sequential clear engine that also runs out of reset.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int              XLEN    = 32,
    parameter int              NREGS   = 32,
    parameter int              NREAD   = 3,
    parameter int              SP_IDX  = SP_IDX_DEF,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(SP_INIT_DEF),
    parameter bit              SP_LOCK = 1'b1,
    localparam int             AW      = $clog2(NREGS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic [1:0]            wr_en,
    input  logic [2*AW-1:0]       wr_addr,
    input  logic [2*XLEN-1:0]     wr_data,
    input  logic                  issue_en,
    input  logic [AW-1:0]         issue_rd,
    input  logic                  clear_req,
    output logic                  clear_busy
);

    localparam logic [AW-1:0] SP_A = AW'(SP_IDX);
    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    rf_state_t       state;
    rf_state_t       state_next;
    logic [AW-1:0]   ptr;
    logic [AW-1:0]   ptr_next;
    logic [XLEN-1:0] regs [NREGS];

    logic [AW-1:0]   wa [2];
    logic [XLEN-1:0] wd [2];
    logic [1:0]      wr_legal;
    logic [AW-1:0]   rd_idx [NREAD];
    logic [NREAD-1:0] sb_rd_busy;

    // A write only counts when idle and not aimed at x0 or a locked stack pointer.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            wa[k]       = wr_addr[k*AW +: AW];
            wd[k]       = wr_data[k*XLEN +: XLEN];
            wr_legal[k] = wr_en[k] && (state == IDLE) && (wa[k] != '0)
                          && !(SP_LOCK && (wa[k] == SP_A));
        end
        for (int i = 0; i < NREAD; i++) begin
            rd_idx[i] = rd_addr[i*AW +: AW];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = '0;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                ptr_next = ptr + AW'(1);
                if (ptr == LAST) begin
                    state_next = IDLE;
                    ptr_next   = '0;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    assign clear_busy = (state == CLEAR);

    // Storage has no reset; its contents come only from the clear walk.
    always_ff @(posedge clock) begin
        if (state == CLEAR) begin
            regs[ptr] <= (ptr == SP_A) ? SP_INIT : '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (wr_legal[k]) begin
                    regs[wa[k]] <= wd[k];
                end
            end
        end
    end

    // Later write port overrides earlier one, matching commit priority.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NREAD; i++) begin
            if ((state == IDLE) && (rd_idx[i] != '0)) begin
                rd_data[i*XLEN +: XLEN] = regs[rd_idx[i]];
                for (int k = 0; k < 2; k++) begin
                    if (wr_legal[k] && (wa[k] == rd_idx[i])) begin
                        rd_data[i*XLEN +: XLEN] = wd[k];
                    end
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NREAD (NREAD),
        .AW    (AW)
    ) u_scoreboard (
        .clock   (clock),
        .reset   (reset),
        .flush   (state == CLEAR),
        .set_en  (issue_en && (state == IDLE) && (issue_rd != '0)),
        .set_idx (issue_rd),
        .clr_en  (wr_legal),
        .clr_idx ({wa[1], wa[0]}),
        .rd_addr (rd_addr),
        .rd_busy (sb_rd_busy)
    );

    assign rd_busy = sb_rd_busy & {NREAD{state == IDLE}};

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against an array-level reference model.
module tb_regfile_mp;
    import regfile_mp_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 3;
    localparam int AW    = 5;
    localparam logic [31:0] SP_VAL = SP_INIT_DEF;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [NREAD*AW-1:0]   rd_addr;
    logic [NREAD*XLEN-1:0] rd_data;
    logic [NREAD-1:0]      rd_busy;
    logic [1:0]            wr_en;
    logic [2*AW-1:0]       wr_addr;
    logic [2*XLEN-1:0]     wr_data;
    logic                  issue_en;
    logic [AW-1:0]         issue_rd;
    logic                  clear_req;
    logic                  clear_busy;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
        .clock      (clock),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .issue_en   (issue_en),
        .issue_rd   (issue_rd),
        .clear_req  (clear_req),
        .clear_busy (clear_busy)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int failures = 0;

    int          ra [NREAD];
    bit          we [2];
    int          wa [2];
    logic [31:0] wd [2];
    bit          iss;
    int          iss_rd;
    bit          clr;

    logic [31:0] mem [NREGS];
    bit          busy_m [NREGS];
    bit          in_clear;
    int          clear_left;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input int k);
        return !in_clear && we[k] && (wa[k] != 0) && (wa[k] != SP_IDX_DEF);
    endfunction

    task automatic modelWipe();
        for (int r = 0; r < NREGS; r++) begin
            mem[r]    = (r == SP_IDX_DEF) ? SP_VAL : 32'h0;
            busy_m[r] = 1'b0;
        end
    endtask

    task automatic setIdle();
        for (int i = 0; i < NREAD; i++) ra[i] = 0;
        for (int k = 0; k < 2; k++) begin
            we[k] = 1'b0;
            wa[k] = 0;
            wd[k] = 32'h0;
        end
        iss    = 1'b0;
        iss_rd = 0;
        clr    = 1'b0;
    endtask

    task automatic driveInputs();
        for (int i = 0; i < NREAD; i++) rd_addr[i*AW +: AW] = AW'(ra[i]);
        for (int k = 0; k < 2; k++) begin
            wr_en[k]               = we[k];
            wr_addr[k*AW +: AW]    = AW'(wa[k]);
            wr_data[k*XLEN +: XLEN] = wd[k];
        end
        issue_en  = iss;
        issue_rd  = AW'(iss_rd);
        clear_req = clr;
    endtask

    // Drive, settle, and compare every combinational output against the model.
    task automatic applyStimulus();
        logic [31:0] ed;
        bit          eb;
        driveInputs();
        #1;
        checkOutput("clear_busy", clear_busy, in_clear);
        for (int i = 0; i < NREAD; i++) begin
            ed = 32'h0;
            eb = 1'b0;
            if (!in_clear && ra[i] != 0) begin
                ed = mem[ra[i]];
                eb = busy_m[ra[i]];
                for (int k = 0; k < 2; k++) begin
                    if (legal(k) && wa[k] == ra[i]) begin
                        ed = wd[k];
                        eb = 1'b0;
                    end
                end
            end
            checkOutput($sformatf("rd_data[%0d] x%0d", i, ra[i]), rd_data[i*XLEN +: XLEN], ed);
            checkOutput($sformatf("rd_busy[%0d] x%0d", i, ra[i]), rd_busy[i], eb);
        end
    endtask

    task automatic clockEdge();
        @(posedge clock);
        if (in_clear) begin
            clear_left--;
            if (clear_left == 0) in_clear = 1'b0;
        end else if (clr) begin
            in_clear   = 1'b1;
            clear_left = NREGS;
            modelWipe();
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (legal(k)) begin
                    mem[wa[k]]    = wd[k];
                    busy_m[wa[k]] = 1'b0;
                end
            end
            if (iss && iss_rd != 0) busy_m[iss_rd] = 1'b1;
        end
        @(negedge clock);
    endtask

    task automatic resetDut();
        setIdle();
        ra[0] = 2; ra[1] = 5; ra[2] = 7;
        driveInputs();
        reset = 1'b1;
        #1;
        checkOutput("reset clear_busy", clear_busy, 1'b1);
        checkOutput("reset rd_data", rd_data, '0);
        checkOutput("reset rd_busy", rd_busy, '0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset      = 1'b0;
        in_clear   = 1'b1;
        clear_left = NREGS;
        modelWipe();
    endtask

    task automatic countClear();
        int cnt;
        cnt = 0;
        setIdle();
        while (clear_busy === 1'b1 && cnt < 200) begin
            applyStimulus();
            clockEdge();
            cnt++;
        end
        checkOutput("clear cycle count", cnt, NREGS);
    endtask

    function automatic int rndAddr();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREGS - 1))
                                           : int'($urandom_range(0, 9));
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b0;
        in_clear = 1'b0;
        clear_left = 0;
        setIdle();
        driveInputs();
        @(negedge clock);

        resetDut();
        countClear();

        setIdle();
        ra[0] = 2; ra[1] = 5;
        applyStimulus();
        checkOutput("sp after reset", rd_data[0 +: XLEN], SP_VAL);
        checkOutput("x5 after reset", rd_data[XLEN +: XLEN], 32'h0);
        clockEdge();

        setIdle();
        we[0] = 1; wa[0] = 5; wd[0] = 32'hA;
        we[1] = 1; wa[1] = 5; wd[1] = 32'hB;
        ra[0] = 5;
        applyStimulus();
        checkOutput("dual write bypass x5", rd_data[0 +: XLEN], 32'hB);
        clockEdge();
        setIdle();
        ra[0] = 5;
        applyStimulus();
        checkOutput("dual write stored x5", rd_data[0 +: XLEN], 32'hB);
        clockEdge();

        setIdle();
        we[0] = 1; wa[0] = 0; wd[0] = 32'hFFFF_FFFF;
        we[1] = 1; wa[1] = 2; wd[1] = 32'h1234;
        ra[0] = 0; ra[1] = 2;
        applyStimulus();
        checkOutput("x0 no bypass", rd_data[0 +: XLEN], 32'h0);
        checkOutput("sp locked no bypass", rd_data[XLEN +: XLEN], SP_VAL);
        clockEdge();
        setIdle();
        ra[0] = 0; ra[1] = 2;
        applyStimulus();
        checkOutput("x0 stays zero", rd_data[0 +: XLEN], 32'h0);
        checkOutput("sp unchanged", rd_data[XLEN +: XLEN], SP_VAL);
        clockEdge();

        setIdle();
        iss = 1; iss_rd = 7;
        applyStimulus();
        clockEdge();
        setIdle();
        ra[0] = 7;
        applyStimulus();
        checkOutput("x7 busy after issue", rd_busy[0], 1'b1);
        clockEdge();
        setIdle();
        we[0] = 1; wa[0] = 7; wd[0] = 32'h77;
        iss = 1; iss_rd = 7; ra[0] = 7;
        applyStimulus();
        clockEdge();
        setIdle();
        ra[0] = 7;
        applyStimulus();
        checkOutput("x7 set wins over clear", rd_busy[0], 1'b1);
        clockEdge();
        setIdle();
        we[1] = 1; wa[1] = 7; wd[1] = 32'h88;
        applyStimulus();
        clockEdge();
        setIdle();
        ra[0] = 7;
        applyStimulus();
        checkOutput("x7 busy cleared", rd_busy[0], 1'b0);
        checkOutput("x7 data", rd_data[0 +: XLEN], 32'h88);
        clockEdge();

        setIdle();
        we[0] = 1; wa[0] = 9; wd[0] = 32'h55;
        applyStimulus();
        clockEdge();
        setIdle();
        iss = 1; iss_rd = 9;
        applyStimulus();
        clockEdge();
        setIdle();
        clr = 1; ra[0] = 9;
        applyStimulus();
        clockEdge();
        n = 0;
        while (clear_busy === 1'b1 && n < 200) begin
            setIdle();
            we[0] = 1; wa[0] = 9; wd[0] = $urandom;
            iss = 1; iss_rd = 9;
            clr = bit'($urandom_range(0, 1));
            ra[0] = 9;
            applyStimulus();
            clockEdge();
            n++;
        end
        checkOutput("clear_req cycle count", n, NREGS);
        setIdle();
        ra[0] = 9;
        applyStimulus();
        checkOutput("x9 after clear", rd_data[0 +: XLEN], 32'h0);
        checkOutput("x9 busy after clear", rd_busy[0], 1'b0);
        clockEdge();

        setIdle();
        clr = 1;
        applyStimulus();
        clockEdge();
        repeat (10) begin
            setIdle();
            applyStimulus();
            clockEdge();
        end
        resetDut();
        countClear();

        repeat (400) begin
            setIdle();
            for (int i = 0; i < NREAD; i++) ra[i] = rndAddr();
            for (int k = 0; k < 2; k++) begin
                we[k] = bit'($urandom_range(0, 1));
                wa[k] = rndAddr();
                wd[k] = $urandom;
            end
            iss    = ($urandom_range(0, 9) < 3);
            iss_rd = rndAddr();
            clr    = ($urandom_range(0, 79) == 0);
            applyStimulus();
            clockEdge();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
